// File: rtl/axis_packet_arbiter.sv
// Two-port AXI-Stream packet arbiter: round-robin per packet, one arbitration cycle in IDLE,
// registered output stage (1 beat/cycle when m00 ready), granted port stalls on output backpressure.
module axis_packet_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_PKT_CNT_WIDTH    = 16
) (
  input  logic                            axis_aclk,
  input  logic                            axis_areset,

  input  logic                            s00_axis_tvalid,
  input  logic                            s00_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                            s00_axis_tready,

  input  logic                            s01_axis_tvalid,
  input  logic                            s01_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s01_axis_tstrb,
  output logic                            s01_axis_tready,

  output logic                            m00_axis_tvalid,
  output logic                            m00_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  input  logic                            m00_axis_tready,

  output logic                            grant,
  output logic                            busy,
  output logic [C_PKT_CNT_WIDTH-1:0]      pkt_cnt0,
  output logic [C_PKT_CNT_WIDTH-1:0]      pkt_cnt1
);

  localparam int STRB_W = C_AXIS_TDATA_WIDTH / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic                        grant_q, grant_d;
  logic                        last_grant_q, last_grant_d;
  logic                        m_vld_q, m_vld_d;
  logic                        m_last_q, m_last_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] m_dat_q, m_dat_d;
  logic [STRB_W-1:0]           m_strb_q, m_strb_d;
  logic [C_PKT_CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [C_PKT_CNT_WIDTH-1:0]  cnt1_q, cnt1_d;

  logic                        sel_vld;
  logic                        sel_last;
  logic [C_AXIS_TDATA_WIDTH-1:0] sel_dat;
  logic [STRB_W-1:0]           sel_strb;
  logic                        out_free;
  logic                        xfer;

  // Source mux follows the registered grant, so it cannot change inside a packet.
  always_comb begin
    sel_vld  = s00_axis_tvalid;
    sel_last = s00_axis_tlast;
    sel_dat  = s00_axis_tdata;
    sel_strb = s00_axis_tstrb;
    if (grant_q) begin
      sel_vld  = s01_axis_tvalid;
      sel_last = s01_axis_tlast;
      sel_dat  = s01_axis_tdata;
      sel_strb = s01_axis_tstrb;
    end
  end

  assign out_free = !m_vld_q || m00_axis_tready;

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    cnt0_d          = cnt0_q;
    cnt1_d          = cnt1_q;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    xfer            = 1'b0;

    case (state_q)
      IDLE: begin
        if (s00_axis_tvalid || s01_axis_tvalid) begin
          state_d = BUSY;
          if (s00_axis_tvalid && s01_axis_tvalid) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = s01_axis_tvalid;
          end
        end
      end
      BUSY: begin
        s00_axis_tready = !grant_q && out_free;
        s01_axis_tready = grant_q && out_free;
        xfer            = sel_vld && out_free;
        if (xfer && sel_last) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          if (grant_q) begin
            cnt1_d = cnt1_q + C_PKT_CNT_WIDTH'(1);
          end else begin
            cnt0_d = cnt0_q + C_PKT_CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: a new beat may load on the same edge the old one drains.
  always_comb begin
    m_vld_d  = m_vld_q;
    m_last_d = m_last_q;
    m_dat_d  = m_dat_q;
    m_strb_d = m_strb_q;
    if (xfer) begin
      m_vld_d  = 1'b1;
      m_last_d = sel_last;
      m_dat_d  = sel_dat;
      m_strb_d = sel_strb;
    end else if (m00_axis_tready) begin
      m_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      m_vld_q      <= 1'b0;
      m_last_q     <= 1'b0;
      m_dat_q      <= '0;
      m_strb_q     <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_vld_q      <= m_vld_d;
      m_last_q     <= m_last_d;
      m_dat_q      <= m_dat_d;
      m_strb_q     <= m_strb_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign m00_axis_tvalid = m_vld_q;
  assign m00_axis_tlast  = m_last_q;
  assign m00_axis_tdata  = m_dat_q;
  assign m00_axis_tstrb  = m_strb_q;
  assign grant           = grant_q;
  assign busy            = (state_q == BUSY);
  assign pkt_cnt0        = cnt0_q;
  assign pkt_cnt1        = cnt1_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: per-cycle vector table plus scoreboarded traffic sequences.
module tb_axis_packet_arbiter;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s0v, s0l, s0r;
  logic [DW-1:0] s0d;
  logic [SW-1:0] s0s;
  logic          s1v, s1l, s1r;
  logic [DW-1:0] s1d;
  logic [SW-1:0] s1s;
  logic          mv, ml, mrdy;
  logic [DW-1:0] md;
  logic [SW-1:0] ms;
  logic          gr, bsy;
  logic [CW-1:0] c0, c1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axis_packet_arbiter #(.C_AXIS_TDATA_WIDTH(DW), .C_PKT_CNT_WIDTH(CW)) dut (
    .axis_aclk(clk), .axis_areset(rst),
    .s00_axis_tvalid(s0v), .s00_axis_tlast(s0l), .s00_axis_tdata(s0d),
    .s00_axis_tstrb(s0s), .s00_axis_tready(s0r),
    .s01_axis_tvalid(s1v), .s01_axis_tlast(s1l), .s01_axis_tdata(s1d),
    .s01_axis_tstrb(s1s), .s01_axis_tready(s1r),
    .m00_axis_tvalid(mv), .m00_axis_tlast(ml), .m00_axis_tdata(md),
    .m00_axis_tstrb(ms), .m00_axis_tready(mrdy),
    .grant(gr), .busy(bsy), .pkt_cnt0(c0), .pkt_cnt1(c1)
  );

  typedef struct {
    logic          s0v, s0l;
    logic [DW-1:0] s0d;
    logic          mrdy;
    logic          e_s0r, e_mv;
    logic [DW-1:0] e_md;
    logic          e_ml, e_gr, e_busy;
    logic [CW-1:0] e_c0;
  } vec_t;

  vec_t vt[13];

  logic [DW-1:0] q0d[$], q1d[$], expd[$];
  bit            q0l[$], q1l[$], expl[$];

  function automatic vec_t mk(logic v, logic l, logic [DW-1:0] d, logic r, logic er, logic emv,
                              logic [DW-1:0] emd, logic eml, logic egr, logic eb, logic [CW-1:0] ec0);
    vec_t t;
    t.s0v = v; t.s0l = l; t.s0d = d; t.mrdy = r;
    t.e_s0r = er; t.e_mv = emv; t.e_md = emd; t.e_ml = eml;
    t.e_gr = egr; t.e_busy = eb; t.e_c0 = ec0;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    s0v = 0; s0l = 0; s0d = '0; s0s = '1;
    s1v = 0; s1l = 0; s1d = '0; s1s = '1;
    mrdy = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int port, input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (port == 0) begin q0d.push_back(base + DW'(i)); q0l.push_back(i == n - 1); end
      else           begin q1d.push_back(base + DW'(i)); q1l.push_back(i == n - 1); end
    end
  endtask

  task automatic expect_pkt(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      expd.push_back(base + DW'(i));
      expl.push_back(i == n - 1);
    end
  endtask

  // Drives queued packets, models output backpressure and scoreboards every emitted beat.
  task automatic run_traffic(input string name, input int gap_after, input int gap_len,
                             input bit toggle, input bit check_lock);
    int cyc, sent0, gap_rem;
    bit open0, prev_stall, done, in_gap, acc0, acc1;
    logic [DW-1:0] prev_dat;
    cyc = 0; sent0 = 0; gap_rem = gap_len; open0 = 0; prev_stall = 0; done = 0; prev_dat = '0;
    while (!done && cyc < 400) begin
      in_gap = (sent0 == gap_after) && (gap_rem > 0);
      s0v = (q0d.size() > 0) && !in_gap;
      s0d = (q0d.size() > 0) ? q0d[0] : '0;
      s0l = (q0l.size() > 0) ? q0l[0] : 1'b0;
      s1v = (q1d.size() > 0);
      s1d = (q1d.size() > 0) ? q1d[0] : '0;
      s1l = (q1l.size() > 0) ? q1l[0] : 1'b0;
      mrdy = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (s0r && s1r) check({name, " both_tready"}, 64'(s0r & s1r), 64'd0);
      if (prev_stall) check({name, " stall_hold"}, {31'd0, mv, md}, {31'd0, 1'b1, prev_dat});
      if (check_lock && open0) check({name, " lock"}, {62'd0, gr, s1r}, 64'd0);
      if (mv && mrdy) begin
        if (expd.size() == 0) begin
          check({name, " extra_beat"}, 64'(md), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check({name, " beat"}, {27'd0, ml, ms, md}, {27'd0, expl[0], 4'hF, expd[0]});
          void'(expd.pop_front());
          void'(expl.pop_front());
        end
      end
      prev_stall = mv && !mrdy;
      prev_dat   = md;
      acc0 = s0v && s0r;
      acc1 = s1v && s1r;
      if (in_gap) gap_rem--;
      @(posedge clk);
      #1;
      if (acc0) begin
        open0 = !q0l[0];
        void'(q0d.pop_front());
        void'(q0l.pop_front());
        sent0++;
      end
      if (acc1) begin
        void'(q1d.pop_front());
        void'(q1l.pop_front());
      end
      cyc++;
      done = (q0d.size() == 0) && (q1d.size() == 0) && (expd.size() == 0);
    end
    check({name, " completed_in_budget"}, 64'(done), 64'd1);
    idle_inputs();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(1, 0, 32'h1, 1, 0, 0, 32'h0, 0, 0, 0, 2'd0);
    vt[1]  = mk(1, 0, 32'h1, 1, 1, 0, 32'h0, 0, 0, 1, 2'd0);
    vt[2]  = mk(1, 0, 32'h2, 1, 1, 1, 32'h1, 0, 0, 1, 2'd0);
    vt[3]  = mk(1, 0, 32'h3, 1, 1, 1, 32'h2, 0, 0, 1, 2'd0);
    vt[4]  = mk(1, 1, 32'h4, 1, 1, 1, 32'h3, 0, 0, 1, 2'd0);
    vt[5]  = mk(0, 0, 32'h0, 1, 0, 1, 32'h4, 1, 0, 0, 2'd1);
    vt[6]  = mk(0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 2'd1);
    vt[7]  = mk(1, 1, 32'h9, 1, 0, 0, 32'h0, 0, 0, 0, 2'd1);
    vt[8]  = mk(1, 1, 32'h9, 1, 1, 0, 32'h0, 0, 0, 1, 2'd1);
    vt[9]  = mk(0, 0, 32'h0, 0, 0, 1, 32'h9, 1, 0, 0, 2'd2);
    vt[10] = mk(0, 0, 32'h0, 0, 0, 1, 32'h9, 1, 0, 0, 2'd2);
    vt[11] = mk(0, 0, 32'h0, 1, 0, 1, 32'h9, 1, 0, 0, 2'd2);
    vt[12] = mk(0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 2'd2);

    // Reset state, with both requesters asserting valid to prove tready stays low.
    idle_inputs();
    rst = 1;
    s0v = 1; s1v = 1;
    @(negedge clk);
    check("reset_state", {19'd0, mv, ml, md, ms, s0r, s1r, gr, bsy, c0, c1},
          {19'd0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});

    // Single-port 4-beat packet, then a single-beat packet with output stall.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      s0v = vt[i].s0v; s0l = vt[i].s0l; s0d = vt[i].s0d; mrdy = vt[i].mrdy;
      @(negedge clk);
      check($sformatf("vec%0d_ctrl", i), {51'd0, s0r, s1r, mv, gr, bsy, c0, c1},
            {51'd0, vt[i].e_s0r, 1'b0, vt[i].e_mv, vt[i].e_gr, vt[i].e_busy, vt[i].e_c0, 2'd0});
      if (vt[i].e_mv)
        check($sformatf("vec%0d_data", i), {31'd0, ml, md}, {31'd0, vt[i].e_ml, vt[i].e_md});
      @(posedge clk);
      #1;
    end

    // Contention: both valid from reset, three 2-beat packets each; port 0 wins first.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push(0, 32'h100 + 32'(k * 2), 2);
      push(1, 32'h200 + 32'(k * 2), 2);
      expect_pkt(32'h100 + 32'(k * 2), 2);
      expect_pkt(32'h200 + 32'(k * 2), 2);
    end
    run_traffic("contention", -1, 0, 0, 0);
    check("contention_cnts", {60'd0, c0, c1}, {60'd0, 2'd3, 2'd3});

    // Backpressure: 8-beat packet on s01 with m00 ready toggling.
    do_reset();
    push(1, 32'h300, 8);
    expect_pkt(32'h300, 8);
    run_traffic("backpressure", -1, 0, 1, 0);
    check("backpressure_cnts", {60'd0, c0, c1}, {60'd0, 2'd0, 2'd1});

    // Mid-packet gap on s00 while s01 waits.
    do_reset();
    push(0, 32'h400, 4);
    push(1, 32'h500, 1);
    expect_pkt(32'h400, 4);
    expect_pkt(32'h500, 1);
    run_traffic("gap", 2, 3, 0, 1);
    check("gap_cnts", {60'd0, c0, c1}, {60'd0, 2'd1, 2'd1});

    // Reset asserted mid-packet between clock edges.
    do_reset();
    s0v = 1; s0l = 0; s0d = 32'h600;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s0d = 32'h601;
    @(posedge clk); #1;
    s0d = 32'h602;
    check("pre_reset_beat", {31'd0, mv, md}, {31'd0, 1'b1, 32'h601});
    #2;
    rst = 1;
    #1;
    check("async_reset", {24'd0, mv, md, s0r, bsy, c0, gr},
          {24'd0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0});
    idle_inputs();
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    push(0, 32'h700, 4);
    expect_pkt(32'h700, 4);
    run_traffic("post_reset", -1, 0, 0, 0);
    check("post_reset_cnt", {60'd0, c0, c1}, {60'd0, 2'd1, 2'd0});

    // Counter wrap with a 2-bit counter: five packets read back as 1.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push(0, 32'h800 + 32'(k), 1);
      expect_pkt(32'h800 + 32'(k), 1);
    end
    run_traffic("wrap", -1, 0, 0, 0);
    check("wrap_cnt", {60'd0, c0, c1}, {60'd0, 2'd1, 2'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
